psum_accum_requant: RTL

Registered consumer of the combinational MAC partial-sum output (psum, 2*WIDTH_DATA bits signed) in the conv1d datapath. Accumulates a variable-length group of psum beats (kernel taps x input channels) into a guarded saturating accumulator. On the group's last beat it requantizes the total (arithmetic shift, round, optional ReLU, saturate) to one WIDTH_DATA output feature. Output uses a valid/ready handshake toward the activation/line-buffer writer.

---
 rtl/psum_accum_requant_pkg.sv | 18 +
 rtl/psum_accum_requant_requant_sat.sv | 46 ++++
 rtl/psum_accum_requant.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/psum_accum_requant_pkg.sv
// Shared constants and helpers for the psum accumulate/requantize stage.
package psum_accum_requant_pkg;

    // Feature/weight width used across the conv1d datapath.
    localparam int DEF_WIDTH_DATA = 8;
    // Headroom bits above the psum width inside the accumulator.
    localparam int DEF_GUARD      = 4;
    // Width of the requant shift amount; 2^DEF_SHIFT_W must cover the accumulator width.
    localparam int DEF_SHIFT_W    = 5;

    // Accumulator width for a given feature width and guard.
    function automatic int acc_width(input int width_data, input int guard);
        return 2 * width_data + guard;
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_WIDTH_DATA, DEF_GUARD);

endpackage

// File: rtl/psum_accum_requant_requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift,
// optional ReLU, then saturation to a signed WIDTH_DATA result.
module requant_sat #(
    parameter int ACC_W      = 20,
    parameter int WIDTH_DATA = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    input  logic        [SHIFT_W-1:0]    shift_i,
    input  logic                         relu_i,
    output logic signed [WIDTH_DATA-1:0] data_o,
    output logic                         sat_o
);

    // One extra bit so the rounding constant can never overflow the sum.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] OUT_MAX = RW'((2 ** (WIDTH_DATA - 1)) - 1);
    localparam logic signed [RW-1:0] OUT_MIN = RW'(-(2 ** (WIDTH_DATA - 1)));

    logic signed [RW-1:0] acc_ext;
    logic signed [RW-1:0] round_add;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;
    logic signed [RW-1:0] relu_val;

    assign acc_ext   = RW'(acc_i);
    // Half an LSB of the output grid; zero when no shift is applied.
    assign round_add = (shift_i == '0) ? '0 : (RW'(1) << (shift_i - SHIFT_W'(1)));
    assign rounded   = acc_ext + round_add;
    assign shifted   = rounded >>> shift_i;
    assign relu_val  = (relu_i && shifted[RW-1]) ? '0 : shifted;

    // Clamp to the signed output range and flag when clamping happened.
    always_comb begin
        data_o = relu_val[WIDTH_DATA-1:0];
        sat_o  = 1'b0;
        if (relu_val > OUT_MAX) begin
            data_o = OUT_MAX[WIDTH_DATA-1:0];
            sat_o  = 1'b1;
        end else if (relu_val < OUT_MIN) begin
            data_o = OUT_MIN[WIDTH_DATA-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates groups of MAC partial sums with saturation, then requantizes
// each group total to one output feature behind a valid/ready handshake.
// Pipeline: A (accumulator + group config) -> P (one pending total) -> O (output).
module psum_accum_requant
    import psum_accum_requant_pkg::*;
#(
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int GUARD      = DEF_GUARD,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [2*WIDTH_DATA-1:0] in_psum,
    input  logic                          in_last,
    input  logic        [SHIFT_W-1:0]     cfg_shift,
    input  logic                          cfg_relu,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH_DATA-1:0]  out_data,
    output logic                          out_sat,
    output logic                          ovf_sticky
);

    localparam int ACC_W = acc_width(WIDTH_DATA, GUARD);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage A
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    a_full_q, a_full_d;
    logic [SHIFT_W-1:0]      a_shift_q, a_shift_d;
    logic                    a_relu_q, a_relu_d;
    // Stage P
    logic signed [ACC_W-1:0] p_acc_q, p_acc_d;
    logic                    p_full_q, p_full_d;
    logic [SHIFT_W-1:0]      p_shift_q, p_shift_d;
    logic                    p_relu_q, p_relu_d;
    // Stage O
    logic                    o_valid_q, o_valid_d;
    logic signed [WIDTH_DATA-1:0] o_data_q, o_data_d;
    logic                    o_sat_q, o_sat_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] sum_sat;
    logic signed [ACC_W-1:0] grp_total;
    logic [SHIFT_W-1:0]      grp_shift;
    logic                    grp_relu;
    logic                    p_move;
    logic                    in_fire;
    logic signed [WIDTH_DATA-1:0] rq_data;
    logic                    rq_sat;

    assign psum_ext = ACC_W'(in_psum);
    assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(psum_ext);
    // Overflow when the two top bits of the widened sum disagree.
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_sat  = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

    // The first beat of a group starts fresh and latches the config for the group.
    assign grp_total = a_full_q ? sum_sat   : psum_ext;
    assign grp_shift = a_full_q ? a_shift_q : cfg_shift;
    assign grp_relu  = a_full_q ? a_relu_q  : cfg_relu;

    assign p_move   = p_full_q && (!o_valid_q || out_ready);
    // Depends only on pipeline state and out_ready, never on in_valid/in_last.
    assign in_ready = !rst && (!p_full_q || p_move);
    assign in_fire  = in_valid && in_ready;

    requant_sat #(
        .ACC_W      (ACC_W),
        .WIDTH_DATA (WIDTH_DATA),
        .SHIFT_W    (SHIFT_W)
    ) u_requant (
        .acc_i   (p_acc_q),
        .shift_i (p_shift_q),
        .relu_i  (p_relu_q),
        .data_o  (rq_data),
        .sat_o   (rq_sat)
    );

    // Next-state for all three stages and the sticky overflow flag.
    always_comb begin
        acc_d     = acc_q;
        a_full_d  = a_full_q;
        a_shift_d = a_shift_q;
        a_relu_d  = a_relu_q;
        p_acc_d   = p_acc_q;
        p_full_d  = p_full_q;
        p_shift_d = p_shift_q;
        p_relu_d  = p_relu_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        ovf_d     = ovf_q;

        if (p_move) begin
            p_full_d  = 1'b0;
            o_valid_d = 1'b1;
            o_data_d  = rq_data;
            o_sat_d   = rq_sat;
        end else if (out_ready) begin
            o_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (a_full_q && sum_ovf) begin
                ovf_d = 1'b1;
            end
            if (in_last) begin
                // Group closes: total leaves A for P, A is free this same edge.
                p_full_d  = 1'b1;
                p_acc_d   = grp_total;
                p_shift_d = grp_shift;
                p_relu_d  = grp_relu;
                a_full_d  = 1'b0;
            end else begin
                a_full_d  = 1'b1;
                acc_d     = grp_total;
                a_shift_d = grp_shift;
                a_relu_d  = grp_relu;
            end
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            a_full_q  <= 1'b0;
            a_shift_q <= '0;
            a_relu_q  <= 1'b0;
            p_acc_q   <= '0;
            p_full_q  <= 1'b0;
            p_shift_q <= '0;
            p_relu_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            a_full_q  <= a_full_d;
            a_shift_q <= a_shift_d;
            a_relu_q  <= a_relu_d;
            p_acc_q   <= p_acc_d;
            p_full_q  <= p_full_d;
            p_shift_q <= p_shift_d;
            p_relu_q  <= p_relu_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sat_q   <= o_sat_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid  = o_valid_q;
    assign out_data   = o_data_q;
    assign out_sat    = o_sat_q;
    assign ovf_sticky = ovf_q;

endmodule
